// File: rtl/fp_alu_pkg.sv
// ---------------------------------------------------------------------------
// fp_alu_pkg
// Shared definitions for the floating-point ALU front end.
//   - opcode constants understood by the combinational FP ALU
//   - quiet-NaN pattern returned for illegal opcodes
//   - FSM state encoding of the issuer
//   - helper that flags opcodes the ALU cannot execute
// ---------------------------------------------------------------------------
package fp_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The ALU decodes only the low two opcode bits; any opcode with bit 2 set
  // is outside its instruction set and is answered locally with a NaN.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/fp_alu_issuer_if.sv
// ---------------------------------------------------------------------------
// fp_alu_issuer_if
// Command and response channels of the FP ALU issuer.
//   cmd_*  : valid/ready command channel (op, A, B, tag)
//   rsp_*  : valid/ready response channel (result, flags, illegal, tag)
// Modports:
//   master : the requester that issues commands and consumes responses
//   slave  : the issuer itself
// ---------------------------------------------------------------------------
interface fp_alu_issuer_if #(
  parameter int TAG_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_exception;
  logic             rsp_overflow;
  logic             rsp_underflow;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_exception,
           rsp_overflow, rsp_underflow, rsp_illegal, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_exception,
           rsp_overflow, rsp_underflow, rsp_illegal, rsp_tag
  );

endinterface

// File: rtl/fp_alu_issuer.sv
// ---------------------------------------------------------------------------
// fp_alu_issuer
// Initiator-side front end for a combinational floating-point ALU that lives
// beside this block in the parent. One command is outstanding at a time: the
// operands and opcode are registered onto alu_*, held for SETTLE_CYCLES edges,
// then the ALU result and flags are captured and offered on the response
// channel until consumed. Illegal opcodes bypass the settle window and return
// a quiet NaN with the exception flag set.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   io                command/response channels (slave modport)
//   alu_a, alu_b      registered operands to the ALU
//   alu_operation     registered opcode to the ALU
//   alu_result        ALU result
//   alu_exception     ALU exception flag
//   alu_overflow      ALU overflow flag
//   alu_underflow     ALU underflow flag
//   sticky_exc/ovf/unf  accumulated response flags since the last clear
//   sticky_clr        synchronous clear of the sticky flags
//   busy              high whenever a command is in flight or being returned
// ---------------------------------------------------------------------------
module fp_alu_issuer
  import fp_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int TAG_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_alu_issuer_if.slave       io,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_operation,
  input  logic [31:0]          alu_result,
  input  logic                 alu_exception,
  input  logic                 alu_overflow,
  input  logic                 alu_underflow,
  output logic                 sticky_exc,
  output logic                 sticky_ovf,
  output logic                 sticky_unf,
  input  logic                 sticky_clr,
  output logic                 busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;

  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_exc_q;
  logic             rsp_ovf_q;
  logic             rsp_unf_q;
  logic             rsp_ill_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic             cmd_ready_c;
  logic             accept;
  logic             accept_illegal;
  logic             wait_done;
  logic             capture;
  logic             new_exc;
  logic             new_ovf;
  logic             new_unf;

  // A new command may enter when idle, or while a response is being handed
  // off in the same cycle so that consecutive commands run without a bubble.
  assign cmd_ready_c    = (state == IDLE) || ((state == RESP) && io.rsp_ready);
  assign accept         = io.cmd_valid && cmd_ready_c;
  assign accept_illegal = accept && is_illegal_op(io.cmd_op);
  assign wait_done      = (state == WAIT) && (cnt == '0);

  // Both the end of a settle window and an illegal accept load a fresh
  // response; these are the edges on which the sticky flags accumulate.
  assign capture = wait_done || accept_illegal;
  assign new_exc = accept_illegal || (wait_done && alu_exception);
  assign new_ovf = wait_done && alu_overflow;
  assign new_unf = wait_done && alu_underflow;

  // Command FSM with registered ALU drive, response payload and status.
  // An accept always takes priority because it can only happen in IDLE or
  // during the hand-off cycle of RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      tag_q         <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_exc_q     <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_unf_q     <= 1'b0;
      rsp_ill_q     <= 1'b0;
      rsp_tag_q     <= '0;
      busy          <= 1'b0;
    end else if (accept) begin
      alu_a         <= io.cmd_a;
      alu_b         <= io.cmd_b;
      alu_operation <= io.cmd_op;
      tag_q         <= io.cmd_tag;
      busy          <= 1'b1;
      if (is_illegal_op(io.cmd_op)) begin
        state        <= RESP;
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= QNAN;
        rsp_exc_q    <= 1'b1;
        rsp_ovf_q    <= 1'b0;
        rsp_unf_q    <= 1'b0;
        rsp_ill_q    <= 1'b1;
        rsp_tag_q    <= io.cmd_tag;
      end else begin
        state       <= WAIT;
        rsp_valid_q <= 1'b0;
        cnt         <= CNT_LOAD;
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state        <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_exc_q    <= alu_exception;
            rsp_ovf_q    <= alu_overflow;
            rsp_unf_q    <= alu_underflow;
            rsp_ill_q    <= 1'b0;
            rsp_tag_q    <= tag_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (io.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky status: a capture replaces the clear, so a clear landing on a
  // capture edge leaves exactly the flags of the new response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_exc <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else if (capture) begin
      sticky_exc <= (sticky_exc && !sticky_clr) || new_exc;
      sticky_ovf <= (sticky_ovf && !sticky_clr) || new_ovf;
      sticky_unf <= (sticky_unf && !sticky_clr) || new_unf;
    end else if (sticky_clr) begin
      sticky_exc <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end
  end

  assign io.cmd_ready     = cmd_ready_c;
  assign io.rsp_valid     = rsp_valid_q;
  assign io.rsp_result    = rsp_result_q;
  assign io.rsp_exception = rsp_exc_q;
  assign io.rsp_overflow  = rsp_ovf_q;
  assign io.rsp_underflow = rsp_unf_q;
  assign io.rsp_illegal   = rsp_ill_q;
  assign io.rsp_tag       = rsp_tag_q;

endmodule

// File: tb/tb_fp_alu_issuer.sv
// ---------------------------------------------------------------------------
// tb_fp_alu_issuer
// Two issuers (settle window 2 and 1) share one stimulus stream. Each drives
// a behavioural stand-in for the FP ALU. A transaction-level model per
// instance predicts readiness, response contents, latency and sticky flags.
// ---------------------------------------------------------------------------
module tb_fp_alu_issuer;

  localparam logic [31:0] QNAN_VAL = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] result;
    logic        exc;
    logic        ovf;
    logic        unf;
    logic        ill;
    logic [3:0]  tag;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic sticky_clr;

  fp_alu_issuer_if #(.TAG_W(4)) bus_s2 ();
  fp_alu_issuer_if #(.TAG_W(4)) bus_s1 ();

  logic [31:0] alu_a_o  [2];
  logic [31:0] alu_b_o  [2];
  logic [2:0]  alu_op_o [2];
  logic [34:0] alu_out  [2];
  logic        busy_o   [2];
  logic        sx_o     [2];
  logic        so_o     [2];
  logic        su_o     [2];

  logic        obs_ready [2];
  logic        obs_valid [2];
  logic [31:0] obs_res   [2];
  logic        obs_exc   [2];
  logic        obs_ovf   [2];
  logic        obs_unf   [2];
  logic        obs_ill   [2];
  logic [3:0]  obs_tag   [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // Stand-in for the combinational FP ALU: exact IEEE results for the known
  // operand sets, an arbitrary but deterministic mix otherwise.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [31:0] r;
    if (a == 32'h3FC00000 && b == 32'h40100000 && op[1:0] == 2'b00) return {3'b000, 32'h40700000};
    if (a == 32'h40000000 && b == 32'h40400000 && op[1:0] == 2'b10) return {3'b000, 32'h40C00000};
    if (a == 32'h7F000000 && b == 32'h7F000000 && op[1:0] == 2'b10) return {3'b010, 32'h7F800000};
    if (a == 32'h40C00000 && b == 32'h40000000 && op[1:0] == 2'b11) return {3'b000, 32'h40400000};
    r = (a ^ {b[15:0], b[31:16]}) + {30'd0, op[1:0]};
    return {r[0] & r[5], r[1] & r[7], r[2] & r[9], r};
  endfunction

  assign alu_out[0] = alu_fn(alu_a_o[0], alu_b_o[0], alu_op_o[0]);
  assign alu_out[1] = alu_fn(alu_a_o[1], alu_b_o[1], alu_op_o[1]);

  fp_alu_issuer #(.SETTLE_CYCLES(2), .TAG_W(4)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .io(bus_s2.slave),
    .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]), .alu_operation(alu_op_o[0]),
    .alu_result(alu_out[0][31:0]), .alu_exception(alu_out[0][34]),
    .alu_overflow(alu_out[0][33]), .alu_underflow(alu_out[0][32]),
    .sticky_exc(sx_o[0]), .sticky_ovf(so_o[0]), .sticky_unf(su_o[0]),
    .sticky_clr(sticky_clr), .busy(busy_o[0])
  );

  fp_alu_issuer #(.SETTLE_CYCLES(1), .TAG_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .io(bus_s1.slave),
    .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]), .alu_operation(alu_op_o[1]),
    .alu_result(alu_out[1][31:0]), .alu_exception(alu_out[1][34]),
    .alu_overflow(alu_out[1][33]), .alu_underflow(alu_out[1][32]),
    .sticky_exc(sx_o[1]), .sticky_ovf(so_o[1]), .sticky_unf(su_o[1]),
    .sticky_clr(sticky_clr), .busy(busy_o[1])
  );

  assign obs_ready[0] = bus_s2.cmd_ready;     assign obs_ready[1] = bus_s1.cmd_ready;
  assign obs_valid[0] = bus_s2.rsp_valid;     assign obs_valid[1] = bus_s1.rsp_valid;
  assign obs_res[0]   = bus_s2.rsp_result;    assign obs_res[1]   = bus_s1.rsp_result;
  assign obs_exc[0]   = bus_s2.rsp_exception; assign obs_exc[1]   = bus_s1.rsp_exception;
  assign obs_ovf[0]   = bus_s2.rsp_overflow;  assign obs_ovf[1]   = bus_s1.rsp_overflow;
  assign obs_unf[0]   = bus_s2.rsp_underflow; assign obs_unf[1]   = bus_s1.rsp_underflow;
  assign obs_ill[0]   = bus_s2.rsp_illegal;   assign obs_ill[1]   = bus_s1.rsp_illegal;
  assign obs_tag[0]   = bus_s2.rsp_tag;       assign obs_tag[1]   = bus_s1.rsp_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model per instance: a command in flight with edges left,
  // the response currently on offer, the last accepted operands and stickies.
  int          lat        [2] = '{2, 1};
  bit          m_inflight [2];
  int          m_left     [2];
  bit          m_show     [2];
  rsp_t        m_pend     [2];
  rsp_t        m_exp      [2];
  logic [31:0] m_a        [2];
  logic [31:0] m_b        [2];
  logic [2:0]  m_op       [2];
  bit          m_sx       [2];
  bit          m_so       [2];
  bit          m_su       [2];

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      m_inflight[d] = 0; m_left[d] = 0; m_show[d] = 0;
      m_pend[d] = '0; m_exp[d] = '0;
      m_a[d] = '0; m_b[d] = '0; m_op[d] = '0;
      m_sx[d] = 0; m_so[d] = 0; m_su[d] = 0;
    end
  endtask

  task automatic checkQuiet(input string phase);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_d%0d_rsp_valid", phase, d), obs_valid[d], 0);
      checkOutput($sformatf("%s_d%0d_busy", phase, d), busy_o[d], 0);
      checkOutput($sformatf("%s_d%0d_alu_a", phase, d), alu_a_o[d], 0);
      checkOutput($sformatf("%s_d%0d_alu_b", phase, d), alu_b_o[d], 0);
      checkOutput($sformatf("%s_d%0d_alu_op", phase, d), alu_op_o[d], 0);
      checkOutput($sformatf("%s_d%0d_stickies", phase, d), {sx_o[d], so_o[d], su_o[d]}, 0);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model,
  // advance the model across the edge, then check the registered state.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] tag,
                               input logic rr, input logic clr);
    bit   acc [2];
    bit   cap;
    logic [34:0] f;
    bus_s2.cmd_valid = v;  bus_s1.cmd_valid = v;
    bus_s2.cmd_op    = op; bus_s1.cmd_op    = op;
    bus_s2.cmd_a     = a;  bus_s1.cmd_a     = a;
    bus_s2.cmd_b     = b;  bus_s1.cmd_b     = b;
    bus_s2.cmd_tag   = tag; bus_s1.cmd_tag  = tag;
    bus_s2.rsp_ready = rr; bus_s1.rsp_ready = rr;
    sticky_clr       = clr;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit exp_ready;
      exp_ready = !m_inflight[d] && (!m_show[d] || rr);
      checkOutput($sformatf("d%0d_cmd_ready", d), obs_ready[d], exp_ready);
      checkOutput($sformatf("d%0d_rsp_valid", d), obs_valid[d], m_show[d]);
      checkOutput($sformatf("d%0d_busy", d), busy_o[d], m_inflight[d] || m_show[d]);
      if (m_show[d]) begin
        checkOutput($sformatf("d%0d_rsp_result", d), obs_res[d], m_exp[d].result);
        checkOutput($sformatf("d%0d_rsp_exception", d), obs_exc[d], m_exp[d].exc);
        checkOutput($sformatf("d%0d_rsp_overflow", d), obs_ovf[d], m_exp[d].ovf);
        checkOutput($sformatf("d%0d_rsp_underflow", d), obs_unf[d], m_exp[d].unf);
        checkOutput($sformatf("d%0d_rsp_illegal", d), obs_ill[d], m_exp[d].ill);
        checkOutput($sformatf("d%0d_rsp_tag", d), obs_tag[d], m_exp[d].tag);
      end
      acc[d] = v && exp_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      cap = 0;
      if (m_show[d] && rr) m_show[d] = 0;
      if (m_inflight[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_inflight[d] = 0; m_show[d] = 1; m_exp[d] = m_pend[d]; cap = 1;
        end
      end
      if (acc[d]) begin
        m_a[d] = a; m_b[d] = b; m_op[d] = op;
        if (op[2]) begin
          m_exp[d] = '{result: QNAN_VAL, exc: 1'b1, ovf: 1'b0, unf: 1'b0, ill: 1'b1, tag: tag};
          m_show[d] = 1; cap = 1;
        end else begin
          f = alu_fn(a, b, op);
          m_pend[d] = '{result: f[31:0], exc: f[34], ovf: f[33], unf: f[32], ill: 1'b0, tag: tag};
          m_inflight[d] = 1; m_left[d] = lat[d];
        end
      end
      if (cap) begin
        m_sx[d] = (clr ? 1'b0 : m_sx[d]) | m_exp[d].exc;
        m_so[d] = (clr ? 1'b0 : m_so[d]) | m_exp[d].ovf;
        m_su[d] = (clr ? 1'b0 : m_su[d]) | m_exp[d].unf;
      end else if (clr) begin
        m_sx[d] = 0; m_so[d] = 0; m_su[d] = 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_sticky_exc", d), sx_o[d], m_sx[d]);
      checkOutput($sformatf("d%0d_sticky_ovf", d), so_o[d], m_so[d]);
      checkOutput($sformatf("d%0d_sticky_unf", d), su_o[d], m_su[d]);
      checkOutput($sformatf("d%0d_alu_a", d), alu_a_o[d], m_a[d]);
      checkOutput($sformatf("d%0d_alu_b", d), alu_b_o[d], m_b[d]);
      checkOutput($sformatf("d%0d_alu_op", d), alu_op_o[d], m_op[d]);
    end
  endtask

  task automatic idle(input logic rr, input logic clr);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 4'h0, rr, clr);
  endtask

  task automatic drain();
    repeat (4) idle(1'b1, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic doReset(input string phase);
    bus_s2.cmd_valid = 1'b0; bus_s1.cmd_valid = 1'b0;
    bus_s2.rsp_ready = 1'b0; bus_s1.rsp_ready = 1'b0;
    sticky_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    clearModel();
    checkQuiet(phase);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          pick;
    rst_n = 1'b1;
    bus_s2.cmd_valid = 1'b0; bus_s1.cmd_valid = 1'b0;
    bus_s2.cmd_op = '0; bus_s1.cmd_op = '0;
    bus_s2.cmd_a = '0;  bus_s1.cmd_a = '0;
    bus_s2.cmd_b = '0;  bus_s1.cmd_b = '0;
    bus_s2.cmd_tag = '0; bus_s1.cmd_tag = '0;
    bus_s2.rsp_ready = 1'b0; bus_s1.rsp_ready = 1'b0;
    sticky_clr = 1'b0;
    doReset("reset");

    // Add, tag 5: settle-2 instance responds two edges after accept.
    applyStimulus(1'b1, 3'b000, 32'h3FC00000, 32'h40100000, 4'd5, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("t1_valid_early", obs_valid[0], 0);
    idle(1'b0, 1'b0);
    checkOutput("t1_valid", obs_valid[0], 1);
    checkOutput("t1_result", obs_res[0], 32'h40700000);
    checkOutput("t1_tag", obs_tag[0], 5);
    drain();

    // Multiply held under backpressure, then a hand-off with a new accept.
    applyStimulus(1'b1, 3'b010, 32'h40000000, 32'h40400000, 4'd7, 1'b0, 1'b0);
    repeat (5) idle(1'b0, 1'b0);
    checkOutput("t2_result_held", obs_res[0], 32'h40C00000);
    checkOutput("t2_ready_blocked", obs_ready[0], 0);
    applyStimulus(1'b1, 3'b000, 32'h3FC00000, 32'h40100000, 4'd9, 1'b1, 1'b0);
    checkOutput("t2_b2b_busy", busy_o[0], 1);
    checkOutput("t2_b2b_alu_a", alu_a_o[0], 32'h3FC00000);
    drain();

    // Illegal opcode: one-edge NaN response.
    applyStimulus(1'b1, 3'b101, 32'h12345678, 32'h9ABCDEF0, 4'd3, 1'b0, 1'b0);
    checkOutput("t3_valid", obs_valid[0], 1);
    checkOutput("t3_result", obs_res[0], QNAN_VAL);
    checkOutput("t3_illegal", obs_ill[0], 1);
    checkOutput("t3_sticky_exc", sx_o[0], 1);
    drain();

    // Overflow multiply, clear while idle, then clear on a flag-free capture.
    applyStimulus(1'b1, 3'b010, 32'h7F000000, 32'h7F000000, 4'd1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("t4_rsp_ovf", obs_ovf[0], 1);
    checkOutput("t4_sticky_ovf", so_o[0], 1);
    drain();
    idle(1'b1, 1'b1);
    checkOutput("t4_sticky_ovf_cleared", so_o[0], 0);
    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 4'd2, 1'b1, 1'b0);
    drain();
    applyStimulus(1'b1, 3'b000, 32'h3FC00000, 32'h40100000, 4'd4, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    checkOutput("t4_clr_on_capture", {sx_o[0], so_o[0], su_o[0]}, 0);
    drain();

    // Divide: settle-1 instance answers after one edge, settle-2 not yet.
    applyStimulus(1'b1, 3'b011, 32'h40C00000, 32'h40000000, 4'd6, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("t6_s1_valid", obs_valid[1], 1);
    checkOutput("t6_s1_result", obs_res[1], 32'h40400000);
    checkOutput("t6_s2_not_yet", obs_valid[0], 0);
    drain();

    // Reset one cycle after accept; the aborted command never responds.
    applyStimulus(1'b1, 3'b001, 32'h40000000, 32'h3F800000, 4'd8, 1'b0, 1'b0);
    doReset("t5");
    repeat (4) idle(1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      pick = int'($urandom_range(0, 9));
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      if (pick == 0) begin ra = 32'h7F000000; rb = 32'h7F000000; rop = 3'b010; end
      if (pick == 1) begin ra = 32'h40C00000; rb = 32'h40000000; rop = 3'b011; end
      applyStimulus($urandom_range(0, 9) < 6, rop, ra, rb, 4'($urandom),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
